dev_bus_arbiter: RTL and testbench



---
 rtl/dev_arb_pkg.sv | 27 ++
 rtl/dev_arb_rr.sv | 29 ++
 rtl/dev_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dev_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dev_arb_pkg                                                    |
// | Purpose  : Shared types and constants for the two-master device-bus       |
// |            arbiter: FSM state encoding, master indices, default widths.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package dev_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Master indices; also the encoding of the round-robin pointer
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Default widths: word address [7:2], data, grant counters
  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/dev_arb_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dev_arb_rr                                                     |
// | Purpose  : Two-way round-robin picker, purely combinational.              |
// |            A lone requester always wins; on contention the master named   |
// |            by ptr wins. The pointer register lives in the parent.         |
// | Ports    : req[1:0] in  - request per master (bit index = master)         |
// |            ptr      in  - priority master on contention (M0/M1)           |
// |            win[1:0] out - one-hot winner, 2'b00 when nobody requests      |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dev_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  import dev_arb_pkg::*;

  always_comb begin
    win = 2'b00;
    if (req[0] && (!req[1] || ptr == M0)) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dev_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dev_bus_arbiter                                                |
// | Purpose  : Shares one single-cycle device bus between two masters.        |
// |            IDLE -> ACCESS -> DONE per access, round-robin on contention.  |
// | Ports    : clk, rst            clock, synchronous active-high reset       |
// |            mX_req/we/addr/wd   master request + payload (held until gnt)  |
// |            mX_gnt              one-cycle completion pulse (DONE state)    |
// |            mX_rd               read data, valid with gnt, held afterwards |
// |            DEV_Addr/We/Wd      device bus, registered                     |
// |            DEV_Rd              device read data (combinational on addr)   |
// |            busy                high in ACCESS and DONE                    |
// |            cnt0, cnt1          saturating grant counters (macro only)     |
// | Macro    : DEV_ARB_STATS_EN enables cnt0/cnt1 ports and logic.           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dev_bus_arbiter
  import dev_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [DW-1:0] m0_rd,
  output logic [DW-1:0] m1_rd,
  output logic [AW-1:0] DEV_Addr,
  output logic          DEV_We,
  output logic [DW-1:0] DEV_Wd,
  input  logic [DW-1:0] DEV_Rd,
`ifdef DEV_ARB_STATS_EN
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
`endif
  output logic          busy
);

  if (CW < 1) begin : g_bad_cw
    $error("dev_bus_arbiter: CW must be at least 1");
  end

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;        // priority master on contention
  logic          win_q, win_d;        // master owning the current access
  logic [AW-1:0] dev_addr_q, dev_addr_d;
  logic          dev_we_q, dev_we_d;
  logic [DW-1:0] dev_wd_q, dev_wd_d;
  logic          m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic [DW-1:0] m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
  logic [1:0]    pick;

  dev_arb_rr u_rr (
    .req ({m1_req, m0_req}),
    .ptr (ptr_q),
    .win (pick)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    dev_addr_d = dev_addr_q;
    dev_wd_d   = dev_wd_q;
    dev_we_d   = 1'b0;         // strobe only ever lives for the ACCESS cycle
    m0_gnt_d   = 1'b0;
    m1_gnt_d   = 1'b0;
    m0_rd_d    = m0_rd_q;
    m1_rd_d    = m1_rd_q;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          win_d      = pick[1] ? M1 : M0;
          dev_addr_d = pick[1] ? m1_addr : m0_addr;
          dev_we_d   = pick[1] ? m1_we : m0_we;
          dev_wd_d   = pick[1] ? m1_wd : m0_wd;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured for writes too; masters ignore it then.
        if (win_q == M1) begin
          m1_rd_d  = DEV_Rd;
          m1_gnt_d = 1'b1;
        end else begin
          m0_rd_d  = DEV_Rd;
          m0_gnt_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = ~win_q;      // hand priority to the other master
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= M0;
      win_q      <= M0;
      dev_addr_q <= '0;
      dev_we_q   <= 1'b0;
      dev_wd_q   <= '0;
      m0_gnt_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
      m0_rd_q    <= '0;
      m1_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      dev_addr_q <= dev_addr_d;
      dev_we_q   <= dev_we_d;
      dev_wd_q   <= dev_wd_d;
      m0_gnt_q   <= m0_gnt_d;
      m1_gnt_q   <= m1_gnt_d;
      m0_rd_q    <= m0_rd_d;
      m1_rd_q    <= m1_rd_d;
    end
  end

  assign DEV_Addr = dev_addr_q;
  assign DEV_We   = dev_we_q;
  assign DEV_Wd   = dev_wd_q;
  assign m0_gnt   = m0_gnt_q;
  assign m1_gnt   = m1_gnt_q;
  assign m0_rd    = m0_rd_q;
  assign m1_rd    = m1_rd_q;
  assign busy     = (state_q != IDLE);

`ifdef DEV_ARB_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Count completed grants, saturating instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (state_q == DONE) begin
      if (win_q == M0 && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CW'(1);
      if (win_q == M1 && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dev_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dev_bus_arbiter                                             |
// | Purpose  : Self-checking bench for dev_bus_arbiter: table of single       |
// |            accesses plus hand-written timing, contention, streaming and   |
// |            reset-abort sequences. Expected grants go into a scoreboard    |
// |            queue when requested and are popped when a gnt pulse appears.  |
// |            Stats checks are compiled only with DEV_ARB_STATS_EN.          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_dev_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [5:0]  m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rd, m1_rd;
  logic [5:0]  DEV_Addr;
  logic        DEV_We;
  logic [31:0] DEV_Wd, DEV_Rd;
  logic        busy;
`ifdef DEV_ARB_STATS_EN
  logic [1:0]  cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  dev_bus_arbiter #(.AW(6), .DW(32), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rd(m0_rd), .m1_rd(m1_rd),
    .DEV_Addr(DEV_Addr), .DEV_We(DEV_We), .DEV_Wd(DEV_Wd), .DEV_Rd(DEV_Rd),
`ifdef DEV_ARB_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .busy(busy)
  );

  // Device: 64-word register file, combinational read, write on rising edge.
  logic [31:0] dev_mem [0:63];
  logic        init_mem;
  assign DEV_Rd = dev_mem[DEV_Addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++)
        dev_mem[i] <= (i == 0) ? 32'hCAFE_0001 : (i == 1) ? 32'h1111_2222 : 32'h0;
    end else if (DEV_We) begin
      dev_mem[DEV_Addr] <= DEV_Wd;
    end
  end

  typedef struct { int m; logic [31:0] rd; } exp_t;
  typedef struct { int m; logic we; logic [5:0] addr; logic [31:0] wd; logic [31:0] exp_rd; } vec_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  logic [31:0] shadow [0:63];
  logic [31:0] hold [0:1];
  bit          prev_gnt;
  int          checks = 0, failures = 0;

  // Streaming payloads for run()
  int          n0, n1, m1_after;
  logic        p0_we [0:7], p1_we [0:7];
  logic [5:0]  p0_addr [0:7], p1_addr [0:7];
  logic [31:0] p0_wd [0:7], p1_wd [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int m);
    return (m == 1) ? m1_rd : m0_rd;
  endfunction

  // Expected read data comes from a shadow copy of the device contents.
  task automatic push(input int m, input logic we, input logic [5:0] a, input logic [31:0] wd);
    sb.push_back('{m, shadow[a]});
    if (we) shadow[a] = wd;
  endtask

  // One negedge; every gnt pulse is checked against the scoreboard here.
  task automatic tick();
    exp_t e;
    int   gm;
    @(negedge clk);
    if (m0_gnt || m1_gnt) begin
      chk("gnt_both", 64'(m0_gnt & m1_gnt), 64'(0));
      chk("gnt_back_to_back", 64'(prev_gnt), 64'(0));
      if (sb.size() == 0) begin
        chk("gnt_unexpected", 64'(1), 64'(0));
      end else begin
        e  = sb.pop_front();
        gm = m1_gnt ? 1 : 0;
        chk("gnt_master", 64'(gm), 64'(e.m));
        chk("rd_winner", 64'(rd_of(e.m)), 64'(e.rd));
        hold[e.m] = e.rd;
        chk("rd_other_held", 64'(rd_of(1 - e.m)), 64'(hold[1 - e.m]));
      end
    end
    prev_gnt = m0_gnt | m1_gnt;
  endtask

  task automatic load0(input int i);
    m0_we = p0_we[i]; m0_addr = p0_addr[i]; m0_wd = p0_wd[i]; m0_req = 1'b1;
  endtask

  task automatic load1(input int i);
    m1_we = p1_we[i]; m1_addr = p1_addr[i]; m1_wd = p1_wd[i]; m1_req = 1'b1;
  endtask

  // Masters keep req high while payloads remain; M1 may join after m1_after M0 grants.
  task automatic run(input int budget);
    int g0 = 0;
    int g1 = 0;
    int c  = 0;
    if (n0 > 0) load0(0);
    if (n1 > 0 && m1_after == 0) load1(0);
    while ((g0 < n0 || g1 < n1) && c < budget) begin
      tick();
      c++;
      if (m0_gnt) begin
        g0++;
        if (g0 < n0) load0(g0); else m0_req = 1'b0;
        if (n1 > 0 && m1_after > 0 && g0 == m1_after && g1 == 0) load1(0);
      end
      if (m1_gnt) begin
        g1++;
        if (g1 < n1) load1(g1); else m1_req = 1'b0;
      end
    end
    if (g0 < n0 || g1 < n1) begin
      chk("run_timeout", 64'(g0 + g1), 64'(n0 + n1));
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
  endtask

  initial begin
    rst = 1'b1; init_mem = 1'b1; prev_gnt = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
    for (int i = 0; i < 64; i++) shadow[i] = (i == 0) ? 32'hCAFE_0001 : (i == 1) ? 32'h1111_2222 : 32'h0;
    hold[0] = '0; hold[1] = '0;

    tbl[0] = '{1, 1'b0, 6'd0,  32'h0,         32'hCAFE_0001};
    tbl[1] = '{0, 1'b1, 6'd3,  32'hAAAA_0003, 32'h0};
    tbl[2] = '{1, 1'b0, 6'd3,  32'h0,         32'hAAAA_0003};
    tbl[3] = '{0, 1'b1, 6'd3,  32'h5555_1111, 32'hAAAA_0003};
    tbl[4] = '{0, 1'b0, 6'd3,  32'h0,         32'h5555_1111};
    tbl[5] = '{1, 1'b1, 6'd63, 32'hDEAD_BEEF, 32'h0};
    tbl[6] = '{0, 1'b0, 6'd63, 32'h0,         32'hDEAD_BEEF};

    tick(); tick(); tick();
    init_mem = 1'b0;
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dev_we", 64'(DEV_We), 64'(0));
    chk("rst_dev_addr", 64'(DEV_Addr), 64'(0));
    chk("rst_dev_wd", 64'(DEV_Wd), 64'(0));
    chk("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    chk("rst_rd", 64'({m0_rd, m1_rd}), 64'(0));

    // M0 write: exact cycle timing
    push(0, 1'b1, 6'd1, 32'h1234_5678);
    m0_we = 1'b1; m0_addr = 6'd1; m0_wd = 32'h1234_5678; m0_req = 1'b1;
    tick();
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_dev_we", 64'(DEV_We), 64'(1));
    chk("t1_dev_addr", 64'(DEV_Addr), 64'(1));
    chk("t1_dev_wd", 64'(DEV_Wd), 64'(32'h1234_5678));
    chk("t1_gnt_early", 64'(m0_gnt), 64'(0));
    tick();
    chk("t2_m0_gnt", 64'(m0_gnt), 64'(1));
    chk("t2_busy", 64'(busy), 64'(1));
    chk("t2_dev_we_off", 64'(DEV_We), 64'(0));
    chk("t2_dev_addr_hold", 64'(DEV_Addr), 64'(1));
    m0_req = 1'b0;
    tick();
    chk("t3_busy", 64'(busy), 64'(0));
    chk("t3_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    chk("t3_dev_mem", 64'(dev_mem[1]), 64'(32'h1234_5678));

    // M1 read of device word 0
    push(1, 1'b0, 6'd0, 32'h0);
    m1_we = 1'b0; m1_addr = 6'd0; m1_req = 1'b1;
    tick();
    chk("rd_dev_we", 64'(DEV_We), 64'(0));
    tick();
    chk("rd_m1_gnt", 64'(m1_gnt), 64'(1));
    chk("rd_m1_rd", 64'(m1_rd), 64'(32'hCAFE_0001));
    chk("rd_m0_rd_kept", 64'(m0_rd), 64'(32'h1111_2222));
    m1_req = 1'b0;
    tick();

    // Table of single accesses
    m1_after = 0;
    for (int i = 0; i < 7; i++) begin
      n0 = (tbl[i].m == 0) ? 1 : 0;
      n1 = 1 - n0;
      if (tbl[i].m == 0) begin
        p0_we[0] = tbl[i].we; p0_addr[0] = tbl[i].addr; p0_wd[0] = tbl[i].wd;
      end else begin
        p1_we[0] = tbl[i].we; p1_addr[0] = tbl[i].addr; p1_wd[0] = tbl[i].wd;
      end
      sb.push_back('{tbl[i].m, tbl[i].exp_rd});
      if (tbl[i].we) shadow[tbl[i].addr] = tbl[i].wd;
      run(20);
    end

    // Contention straight after reset: M0, M1, then again M0, M1
    do_reset();
    n0 = 1; n1 = 1; m1_after = 0;
    p0_we[0] = 1'b0; p0_addr[0] = 6'd3;  p0_wd[0] = '0;
    p1_we[0] = 1'b0; p1_addr[0] = 6'd63; p1_wd[0] = '0;
    push(0, 1'b0, 6'd3, 32'h0);
    push(1, 1'b0, 6'd63, 32'h0);
    run(20);
    push(0, 1'b0, 6'd3, 32'h0);
    push(1, 1'b0, 6'd63, 32'h0);
    run(20);
    // Both held for two accesses each: strict alternation
    n0 = 2; n1 = 2;
    p0_we[1] = 1'b1; p0_addr[1] = 6'd5; p0_wd[1] = 32'h0000_0505;
    p1_we[1] = 1'b0; p1_addr[1] = 6'd5; p1_wd[1] = '0;
    push(0, 1'b0, 6'd3, 32'h0);
    push(1, 1'b0, 6'd63, 32'h0);
    push(0, 1'b1, 6'd5, 32'h0000_0505);
    push(1, 1'b0, 6'd5, 32'h0);
    run(40);

    // M0 streams 4 writes; M1 joins after the second one
    n0 = 4; n1 = 1; m1_after = 2;
    for (int i = 0; i < 4; i++) begin
      p0_we[i] = 1'b1; p0_addr[i] = 6'(10 + i); p0_wd[i] = 32'hB000_0000 + 32'(i);
    end
    p1_we[0] = 1'b0; p1_addr[0] = 6'd11; p1_wd[0] = '0;
    push(0, 1'b1, 6'd10, 32'hB000_0000);
    push(0, 1'b1, 6'd11, 32'hB000_0001);
    push(1, 1'b0, 6'd11, 32'h0);
    push(0, 1'b1, 6'd12, 32'hB000_0002);
    push(0, 1'b1, 6'd13, 32'hB000_0003);
    run(60);
    chk("stream_dev_mem", 64'(dev_mem[13]), 64'(32'hB000_0003));

    // Reset in the ACCESS cycle of an M1 write (pointer is M1 beforehand)
    n0 = 1; n1 = 0; m1_after = 0;
    p0_we[0] = 1'b0; p0_addr[0] = 6'd0; p0_wd[0] = '0;
    push(0, 1'b0, 6'd0, 32'h0);
    run(20);
    tick();
    m1_we = 1'b1; m1_addr = 6'd20; m1_wd = 32'h0BAD_F00D; m1_req = 1'b1;
    tick();
    chk("ra_dev_we_on", 64'(DEV_We), 64'(1));
    rst = 1'b1;
    m1_req = 1'b0;
    tick();
    rst = 1'b0;
    shadow[20] = 32'h0BAD_F00D;   // device sampled the strobe at the reset edge
    hold[0] = '0; hold[1] = '0;
    chk("ra_dev_we_off", 64'(DEV_We), 64'(0));
    chk("ra_no_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    chk("ra_busy", 64'(busy), 64'(0));
    chk("ra_rd_cleared", 64'({m0_rd, m1_rd}), 64'(0));
    tick();
    chk("ra_no_gnt_late", 64'({m0_gnt, m1_gnt}), 64'(0));
    chk("ra_idle", 64'(busy), 64'(0));
    // Pointer must be back at M0: contention goes to M0 first
    n0 = 1; n1 = 1;
    p0_we[0] = 1'b0; p0_addr[0] = 6'd20; p0_wd[0] = '0;
    p1_we[0] = 1'b0; p1_addr[0] = 6'd3;  p1_wd[0] = '0;
    push(0, 1'b0, 6'd20, 32'h0);
    push(1, 1'b0, 6'd3, 32'h0);
    run(20);

`ifdef DEV_ARB_STATS_EN
    // Saturating counters with CW=2
    do_reset();
    n0 = 0; n1 = 2; m1_after = 0;
    for (int i = 0; i < 3; i++) begin
      p1_we[i] = 1'b0; p1_addr[i] = 6'd0; p1_wd[i] = '0;
    end
    push(1, 1'b0, 6'd0, 32'h0);
    push(1, 1'b0, 6'd0, 32'h0);
    run(20);
    tick();
    chk("cnt1_after2", 64'(cnt1), 64'(2));
    n1 = 3;
    push(1, 1'b0, 6'd0, 32'h0);
    push(1, 1'b0, 6'd0, 32'h0);
    push(1, 1'b0, 6'd0, 32'h0);
    run(30);
    tick();
    chk("cnt1_saturated", 64'(cnt1), 64'(3));
    chk("cnt0_zero", 64'(cnt0), 64'(0));
`endif

    tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
